// File: rtl/slot_pkg.sv
// slot_pkg: shared definitions for the Apple II slot front end.
//   state_t      - bus-cycle FSM state encoding
//   BUS_SEL_*    - cycle-type codes reported on bus_sel
//   DEF_*        - default timing parameters
//   encode_sel() - select priority encoder (devsel > iosel > iostrobe)
package slot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_HOLD,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [1:0] BUS_SEL_NONE     = 2'b00;
    localparam logic [1:0] BUS_SEL_DEVSEL   = 2'b01;
    localparam logic [1:0] BUS_SEL_IOSEL    = 2'b10;
    localparam logic [1:0] BUS_SEL_IOSTROBE = 2'b11;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_ADDR_SETTLE = 3;
    localparam int DEF_HOLD_CYC    = 2;
    localparam int DEF_TIMEOUT     = 31;

    // Inputs are the synchronised, still active-low select levels.
    function automatic logic [1:0] encode_sel(input logic devsel_s,
                                              input logic iosel_s,
                                              input logic iostrobe_s);
        if (!devsel_s)        return BUS_SEL_DEVSEL;
        else if (!iosel_s)    return BUS_SEL_IOSEL;
        else if (!iostrobe_s) return BUS_SEL_IOSTROBE;
        else                  return BUS_SEL_NONE;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: STAGES-deep flop chain that brings one asynchronous bit into
// the clk_16m domain. Reset loads RESET_VAL so the chain starts at the
// signal's inactive level.
//   clk_16m  in  1  system clock
//   reset    in  1  synchronous, active-high reset
//   din      in  1  asynchronous input
//   dout     out 1  synchronised output
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_16m,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    // NOTE: non-blocking assignments make every stage sample the previous
    // stage's old value, so the chain really is STAGES flops deep.
    always_ff @(posedge clk_16m) begin
        if (reset) chain <= {STAGES{RESET_VAL}};
        else       chain <= {chain[STAGES-2:0], din};
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/apple_bus_sampler.sv
// apple_bus_sampler: synchronises the Apple II slot bus into clk_16m,
// classifies each bus cycle and emits single-clock read/write events.
//   clk_16m      in  1   system clock
//   reset        in  1   synchronous, active-high reset
//   phi0         in  1   Apple phi0, asynchronous
//   rw           in  1   6502 R/W (1 = read), asynchronous
//   devsel_n     in  1   C0nX select, active low
//   iosel_n      in  1   CnXX select, active low
//   iostrobe_n   in  1   C800-CFFF strobe, active low
//   addr_in      in  12  A11..A0, asynchronous
//   data_in      in  8   D7..D0, asynchronous
//   rd_stb       out 1   one-cycle pulse: read cycle decoded
//   wr_stb       out 1   one-cycle pulse: write data captured
//   bus_sel      out 2   cycle type (01 devsel, 10 iosel, 11 iostrobe)
//   bus_addr     out 12  address captured for the current cycle
//   bus_wdata    out 8   write data, valid with wr_stb
//   drive_en     out 1   slot may drive the data bus
//   timeout_err  out 1   one-cycle pulse on cycle abort
module apple_bus_sampler
    import slot_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int ADDR_SETTLE = DEF_ADDR_SETTLE,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        clk_16m,
    input  logic        reset,
    input  logic        phi0,
    input  logic        rw,
    input  logic        devsel_n,
    input  logic        iosel_n,
    input  logic        iostrobe_n,
    input  logic [11:0] addr_in,
    input  logic [7:0]  data_in,
    output logic        rd_stb,
    output logic        wr_stb,
    output logic [1:0]  bus_sel,
    output logic [11:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        drive_en,
    output logic        timeout_err
);

    localparam logic [4:0] SETTLE_LAST = 5'(ADDR_SETTLE - 1);
    localparam logic [4:0] HOLD_LAST   = 5'(HOLD_CYC - 1);
    localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

    logic        phi0_s, rw_s, devsel_s, iosel_s, iostrobe_s;
    logic [11:0] addr_s;
    logic [7:0]  data_s;

    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_phi0 (
        .clk_16m(clk_16m), .reset(reset), .din(phi0), .dout(phi0_s));
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rw (
        .clk_16m(clk_16m), .reset(reset), .din(rw), .dout(rw_s));
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_devsel (
        .clk_16m(clk_16m), .reset(reset), .din(devsel_n), .dout(devsel_s));
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_iosel (
        .clk_16m(clk_16m), .reset(reset), .din(iosel_n), .dout(iosel_s));
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_iostrobe (
        .clk_16m(clk_16m), .reset(reset), .din(iostrobe_n), .dout(iostrobe_s));

    for (genvar i = 0; i < 12; i++) begin : g_sync_addr
        sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync (
            .clk_16m(clk_16m), .reset(reset), .din(addr_in[i]), .dout(addr_s[i]));
    end

    // Same depth as phi0, so data_s stays aligned with phi0_s.
    for (genvar i = 0; i < 8; i++) begin : g_sync_data
        sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync (
            .clk_16m(clk_16m), .reset(reset), .din(data_in[i]), .dout(data_s[i]));
    end

    // One extra flop gives the falling-edge detector and the last
    // phi0-high data sample in the cycle the fall is seen.
    logic       phi0_q;
    logic [7:0] data_q;

    always_ff @(posedge clk_16m) begin
        if (reset) begin
            phi0_q <= 1'b0;
            data_q <= '0;
        end else begin
            phi0_q <= phi0_s;
            data_q <= data_s;
        end
    end

    logic phi0_fall, any_sel;
    assign phi0_fall = phi0_q & ~phi0_s;
    assign any_sel   = ~(devsel_s & iosel_s & iostrobe_s);

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic        latch_now, wdata_load, timeout_hit;
    logic [11:0] addr_q;
    logic [1:0]  sel_q;
    logic [7:0]  wdata_q;
    logic        wr_stb_q;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next  = state;
        latch_now   = 1'b0;
        wdata_load  = 1'b0;
        timeout_hit = 1'b0;
        rd_stb      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_sel) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (!any_sel) begin
                    state_next = ST_IDLE;
                end else if (cnt == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_WAIT_IDLE;
                end else if (cnt == SETTLE_LAST) begin
                    latch_now = 1'b1;
                    if (rw_s) begin
                        rd_stb     = 1'b1;
                        state_next = ST_READ;
                    end else begin
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (cnt == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_WAIT_IDLE;
                end else if (phi0_fall) begin
                    state_next = ST_HOLD;
                end
            end
            ST_WRITE: begin
                if (cnt == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_WAIT_IDLE;
                end else if (phi0_fall) begin
                    wdata_load = 1'b1;
                    state_next = ST_WAIT_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) state_next = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (!any_sel) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_16m) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            sel_q    <= BUS_SEL_NONE;
            wdata_q  <= '0;
            wr_stb_q <= 1'b0;
        end else begin
            state    <= state_next;
            wr_stb_q <= wdata_load;
            if (state_next != state) cnt <= '0;
            else if (cnt != '1)      cnt <= cnt + 5'd1;
            if (latch_now) begin
                addr_q <= addr_s;
                sel_q  <= encode_sel(devsel_s, iosel_s, iostrobe_s);
            end
            if (wdata_load) wdata_q <= data_q;
        end
    end

    // The latch cycle forwards the fresh sample so bus_addr/bus_sel are
    // already valid alongside the combinational rd_stb.
    assign bus_addr    = latch_now ? addr_s : addr_q;
    assign bus_sel     = latch_now ? encode_sel(devsel_s, iosel_s, iostrobe_s) : sel_q;
    assign bus_wdata   = wdata_q;
    assign wr_stb      = wr_stb_q;
    assign timeout_err = timeout_hit;
    assign drive_en    = ((state == ST_READ) && !timeout_hit) || (state == ST_HOLD);

endmodule
